regfile_controller: RTL

Sequencing controller that sits on the other side of the 8-entry register file: it accepts one instruction at a time over a valid/ready handshake and drives the file's read port (`readnum` / `data_out`) and write port (`writenum` / `write` / `data_in`). Each instruction reads up to two source registers through the single read port, computes a result in a small ALU and writes it back to the destination register. It also maintains Z/N/V status flags. It forms the control half of the lab datapath, with the register file as its only storage client.

---
 rtl/regfile_ctrl_pkg.sv | 23 ++
 rtl/regfile_alu.sv | 44 ++++
 rtl/regfile_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_ctrl_pkg
// Brief   : Opcodes and FSM state encoding shared by the register-file controller.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_alu.sv
`default_nettype none
// ============================================================================
// Module  : regfile_alu
// Brief   : Combinational ALU (ADD/AND/MVN) with zero, negative, overflow.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_alu
    import regfile_ctrl_pkg::*;
#(
    parameter int k = 16
) (
    input  logic [k-1:0] a,
    input  logic [k-1:0] b,
    input  logic [1:0]   op,
    output logic [k-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    logic [k-1:0] w_sum;

    assign w_sum = a + b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = w_sum;
                // Same-sign operands producing an opposite-sign result
                overflow = (a[k-1] == b[k-1]) && (w_sum[k-1] != a[k-1]);
            end
            OP_AND:  result = a & b;
            OP_MVN:  result = ~b;
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[k-1];

endmodule : regfile_alu
`default_nettype wire

// File: rtl/regfile_controller.sv
`default_nettype none
// ============================================================================
// Module  : regfile_controller
// Brief   : Sequences one instruction at a time through an 8-entry register file.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_controller
    import regfile_ctrl_pkg::*;
#(
    parameter int k = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   opcode,
    input  logic [2:0]   rd,
    input  logic [2:0]   rn,
    input  logic [2:0]   rm,
    input  logic [k-1:0] imm,
    output logic [2:0]   readnum,
    input  logic [k-1:0] data_out,
    output logic [2:0]   writenum,
    output logic         write,
    output logic [k-1:0] data_in,
    output logic         done,
    output logic         Z,
    output logic         N,
    output logic         V
);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_op;
    logic [2:0]   r_rd;
    logic [2:0]   r_rn;
    logic [2:0]   r_rm;
    logic [k-1:0] r_a;
    logic [k-1:0] r_b;
    logic [k-1:0] r_c;
    logic         r_z;
    logic         r_n;
    logic         r_v;

    logic [k-1:0] w_alu_res;
    logic         w_alu_z;
    logic         w_alu_n;
    logic         w_alu_v;
    logic         w_accept;

    assign w_accept = in_valid && (r_state == ST_WAIT);

    regfile_alu #(.k(k)) u_alu (
        .a        (r_a),
        .b        (r_b),
        .op       (r_op),
        .result   (w_alu_res),
        .zero     (w_alu_z),
        .negative (w_alu_n),
        .overflow (w_alu_v)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT: begin
                if (w_accept) begin
                    case (opcode)
                        OP_MOV:  w_next = ST_WRITE;
                        OP_MVN:  w_next = ST_LOADB;
                        default: w_next = ST_LOADA;
                    endcase
                end
            end
            ST_LOADA: w_next = ST_LOADB;
            ST_LOADB: w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_WRITE;
            ST_WRITE: w_next = ST_WAIT;
            default:  w_next = ST_WAIT;
        endcase
    end

    // Datapath registers; reset also discards any partially executed instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= OP_MOV;
            r_rd <= '0;
            r_rn <= '0;
            r_rm <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= '0;
            r_z  <= 1'b0;
            r_n  <= 1'b0;
            r_v  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_accept) begin
                        r_op <= opcode;
                        r_rd <= rd;
                        r_rn <= rn;
                        r_rm <= rm;
                        if (opcode == OP_MOV) begin
                            r_c <= imm;
                        end
                    end
                end
                ST_LOADA: r_a <= data_out;
                ST_LOADB: r_b <= data_out;
                ST_EXEC: begin
                    r_c <= w_alu_res;
                    r_z <= w_alu_z;
                    r_n <= w_alu_n;
                    r_v <= w_alu_v;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        data_in  = '0;
        done     = 1'b0;
        case (r_state)
            ST_WAIT:  in_ready = 1'b1;
            ST_LOADA: readnum  = r_rn;
            ST_LOADB: readnum  = r_rm;
            ST_WRITE: begin
                write    = 1'b1;
                writenum = r_rd;
                data_in  = r_c;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Z = r_z;
    assign N = r_n;
    assign V = r_v;

endmodule : regfile_controller
`default_nettype wire
